// File: rtl/fir_cfg_sequencer.sv
// AXI4-Lite master that loads FIR tap coefficients from a local shadow table,
// verifies each one by readback and finally arms the filter through its control register.
module fir_cfg_sequencer #(
    parameter int unsigned C_NUM_TAPS     = 4,
    parameter int unsigned C_COEF_BASE    = 32'h0000_0000,
    parameter int unsigned C_CTRL_ADDR    = 32'h0000_0010,
    parameter logic [31:0] C_CTRL_VAL     = 32'h0000_0001,
    parameter int unsigned C_ADDR_WIDTH   = 6,
    parameter int unsigned C_RESP_TIMEOUT = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    coef_wr_en,
    input  logic [3:0]              coef_wr_idx,
    input  logic [31:0]             coef_wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [3:0]              err_idx,
    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_REQ    = 4'd1;
    localparam logic [3:0] S_WR_RESP   = 4'd2;
    localparam logic [3:0] S_RD_REQ    = 4'd3;
    localparam logic [3:0] S_RD_RESP   = 4'd4;
    localparam logic [3:0] S_CTRL_REQ  = 4'd5;
    localparam logic [3:0] S_CTRL_RESP = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    localparam int unsigned      TMO_W    = (C_RESP_TIMEOUT > 1) ? $clog2(C_RESP_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_RESP_TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX = 4'(C_NUM_TAPS - 1);
    localparam logic [3:0]       CTRL_IDX = 4'(C_NUM_TAPS);

    logic [3:0]       state;
    logic [3:0]       idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [31:0]      shadow [16];
    logic [1:0]       fail_code;
    logic [3:0]       fail_idx;

    function automatic logic [C_ADDR_WIDTH-1:0] coef_addr(input logic [3:0] i);
        return C_ADDR_WIDTH'(C_COEF_BASE + {26'd0, i, 2'b00});
    endfunction

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    // A response present in the expiry cycle is checked first, so it wins over the timeout.
    always_comb begin
        fail_code = 2'b00;
        fail_idx  = (state == S_CTRL_RESP) ? CTRL_IDX : idx;
        case (state)
            S_WR_RESP, S_CTRL_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) fail_code = 2'b01;
                end else if (tmo_cnt == TMO_LAST) begin
                    fail_code = 2'b11;
                end
            end
            S_RD_RESP: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00)            fail_code = 2'b01;
                    else if (m_axi_rdata != shadow[idx]) fail_code = 2'b10;
                end else if (tmo_cnt == TMO_LAST) begin
                    fail_code = 2'b11;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            idx           <= '0;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'b00;
            err_idx       <= 4'd0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            for (int i = 0; i < 16; i++) shadow[i] <= '0;
        end else begin
            if (coef_wr_en && !busy && ({28'd0, coef_wr_idx} < C_NUM_TAPS))
                shadow[coef_wr_idx] <= coef_wr_data;

            if (fail_code != 2'b00) begin
                state        <= S_ERR;
                busy         <= 1'b0;
                error        <= 1'b1;
                err_code     <= fail_code;
                err_idx      <= fail_idx;
                m_axi_bready <= 1'b0;
                m_axi_rready <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            state         <= S_WR_REQ;
                            idx           <= '0;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            error         <= 1'b0;
                            err_code      <= 2'b00;
                            err_idx       <= 4'd0;
                            m_axi_awaddr  <= coef_addr(4'd0);
                            m_axi_wdata   <= shadow[0];
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end
                    end
                    // Address and data channels complete independently; either may come first.
                    S_WR_REQ, S_CTRL_REQ: begin
                        if (m_axi_awready) m_axi_awvalid <= 1'b0;
                        if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                        if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                            state        <= (state == S_WR_REQ) ? S_WR_RESP : S_CTRL_RESP;
                            m_axi_bready <= 1'b1;
                            tmo_cnt      <= '0;
                        end
                    end
                    S_WR_RESP: begin
                        if (m_axi_bvalid) begin
                            m_axi_bready <= 1'b0;
                            if (idx == LAST_IDX) begin
                                idx           <= '0;
                                state         <= S_RD_REQ;
                                m_axi_araddr  <= coef_addr(4'd0);
                                m_axi_arvalid <= 1'b1;
                            end else begin
                                idx           <= idx + 4'd1;
                                state         <= S_WR_REQ;
                                m_axi_awaddr  <= coef_addr(idx + 4'd1);
                                m_axi_wdata   <= shadow[idx + 4'd1];
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_RD_REQ: begin
                        if (m_axi_arready) begin
                            m_axi_arvalid <= 1'b0;
                            m_axi_rready  <= 1'b1;
                            tmo_cnt       <= '0;
                            state         <= S_RD_RESP;
                        end
                    end
                    S_RD_RESP: begin
                        if (m_axi_rvalid) begin
                            m_axi_rready <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state         <= S_CTRL_REQ;
                                m_axi_awaddr  <= C_ADDR_WIDTH'(C_CTRL_ADDR);
                                m_axi_wdata   <= C_CTRL_VAL;
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                            end else begin
                                idx           <= idx + 4'd1;
                                state         <= S_RD_REQ;
                                m_axi_araddr  <= coef_addr(idx + 4'd1);
                                m_axi_arvalid <= 1'b1;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_CTRL_RESP: begin
                        if (m_axi_bvalid) begin
                            m_axi_bready <= 1'b0;
                            state        <= S_DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
